// File: rtl/dogx_prog_pkg.sv
// Shared types and constants for the DOGX serial programming port and register bank.
// The frame is a single RW bit, an address field and one or more data words.
package dogx_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ERR
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Bits in a frame that carries exactly one data word.
    function automatic int word_frame_len(input int addr_w, input int reg_w);
        return 1 + addr_w + reg_w;
    endfunction

endpackage

// File: rtl/dogx_sync_edge.sv
// Brings an asynchronous pin into the clock domain and flags its edges.
// rise/fall are single-cycle pulses taken from the last synchroniser stage.
module dogx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & last_q;

endmodule

// File: rtl/dogx_prog_regbank.sv
// Oversampled serial programming port driving a generic register bank.
// Writes land in a shadow copy and reach the active bank only on a clean CS fall.
module dogx_prog_regbank
    import dogx_prog_pkg::*;
#(
    parameter int                      N_REGS      = 16,
    parameter int                      REG_W       = 16,
    parameter int                      ADDR_W      = 4,
    parameter int                      SYNC_STAGES = 2,
    parameter logic [N_REGS*REG_W-1:0] RESET_VAL   = '0
) (
    input  logic                      CLK_24M,
    input  logic                      reset,
    input  logic                      SCLK,
    input  logic                      SDI,
    input  logic                      CS,
    output logic                      SDO,
    output logic                      SDO_EN,
    output logic [N_REGS*REG_W-1:0]   regs_flat,
    output logic                      commit,
    output logic                      frame_err,
    output state_t                    dbg_state
);

    localparam int                CNT_W      = $clog2(word_frame_len(ADDR_W, REG_W));
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(REG_W - 1);
    localparam logic [ADDR_W-1:0] REG_LAST   = ADDR_W'(N_REGS - 1);
    localparam logic [ADDR_W:0]   N_REGS_EXT = (ADDR_W + 1)'(N_REGS);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic sdi_s;

    state_t             state_q, state_d;
    logic               rw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               words_done_q;
    logic [REG_W-1:0]   data_sr_q;
    logic [REG_W-1:0]   active_q [N_REGS];
    logic [REG_W-1:0]   shadow_q [N_REGS];

    logic [ADDR_W-1:0]  addr_shift, addr_inc;
    logic [REG_W-1:0]   word_shift, rd_shifted;
    logic               addr_bad, last_addr_bit, last_data_bit;
    logic               load_shadow, end_frame, do_commit, set_err, clr_err;

    dogx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk (CLK_24M),
        .rst (reset),
        .din (SCLK),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    dogx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk (CLK_24M),
        .rst (reset),
        .din (CS),
        .rise(cs_rise),
        .fall(cs_fall)
    );

    // SDI goes through the same depth as SCLK so the data bit lines up with sclk_rise.
    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) sdi_sync_q <= '0;
        else       sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], SDI};
    end
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    assign addr_shift    = ADDR_W'({addr_q, sdi_s});
    assign addr_bad      = {1'b0, addr_shift} >= N_REGS_EXT;
    assign addr_inc      = (addr_q == REG_LAST) ? '0 : addr_q + ADDR_W'(1);
    assign word_shift    = REG_W'({data_sr_q, sdi_s});
    assign rd_shifted    = active_q[addr_q] << bit_cnt_q;
    assign last_addr_bit = (bit_cnt_q == ADDR_LAST);
    assign last_data_bit = (bit_cnt_q == DATA_LAST);

    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        load_shadow = 1'b0;
        end_frame   = 1'b0;
        do_commit   = 1'b0;
        set_err     = 1'b0;
        clr_err     = 1'b0;
        case (state_q)
            IDLE: if (cs_rise) begin
                load_shadow = 1'b1;
                state_d     = CMD;
            end
            CMD:  if (sclk_rise) state_d = ADDR;
            ADDR: if (sclk_rise && last_addr_bit) state_d = addr_bad ? ERR : DATA;
            default: ;
        endcase
        // CS fall outranks any SCLK edge seen in the same cycle.
        if (state_q != IDLE && cs_fall) begin
            state_d   = IDLE;
            end_frame = 1'b1;
            if (state_q == ERR || state_q == CMD) begin
                set_err = 1'b1;
            end else if (rw_q == RW_WRITE) begin
                if (state_q == DATA && bit_cnt_q == '0 && words_done_q) begin
                    do_commit = 1'b1;
                    clr_err   = 1'b1;
                end else begin
                    set_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK_24M or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_REGS; k++) begin
                active_q[k] <= RESET_VAL[k*REG_W +: REG_W];
                shadow_q[k] <= RESET_VAL[k*REG_W +: REG_W];
            end
            rw_q         <= RW_READ;
            addr_q       <= '0;
            bit_cnt_q    <= '0;
            words_done_q <= 1'b0;
            data_sr_q    <= '0;
            SDO          <= 1'b0;
            SDO_EN       <= 1'b0;
            commit       <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            commit <= do_commit;
            if (set_err)      frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;

            if (load_shadow) begin
                shadow_q     <= active_q;
                addr_q       <= '0;
                bit_cnt_q    <= '0;
                words_done_q <= 1'b0;
            end else if (end_frame) begin
                SDO       <= 1'b0;
                SDO_EN    <= 1'b0;
                bit_cnt_q <= '0;
                if (do_commit) active_q <= shadow_q;
            end else begin
                case (state_q)
                    CMD: if (sclk_rise) rw_q <= sdi_s;
                    ADDR: if (sclk_rise) begin
                        addr_q <= addr_shift;
                        if (last_addr_bit) begin
                            bit_cnt_q <= '0;
                            SDO_EN    <= !addr_bad && (rw_q == RW_READ);
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_ONE;
                        end
                    end
                    DATA: if (rw_q == RW_WRITE) begin
                        if (sclk_rise) begin
                            data_sr_q <= word_shift;
                            if (last_data_bit) begin
                                shadow_q[addr_q] <= word_shift;
                                addr_q           <= addr_inc;
                                words_done_q     <= 1'b1;
                                bit_cnt_q        <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_ONE;
                            end
                        end
                    end else if (sclk_fall) begin
                        // Read data leaves MSB first, one bit per falling SCLK edge.
                        SDO <= rd_shifted[REG_W-1];
                        if (last_data_bit) begin
                            addr_q    <= addr_inc;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < N_REGS; k++) regs_flat[k*REG_W +: REG_W] = active_q[k];
    end

    assign dbg_state = state_q;

endmodule
